// File: rtl/ddr3_lane_rx_align_pkg.sv
// Shared DDR3 PHY definitions: lane width, training defaults and FSM state encodings.
package ddr3_phy_pkg;

    localparam int unsigned DDR3_LANE_W           = 8;
    localparam logic [7:0]  RX_ALIGN_PATTERN_DEF  = 8'h0F;
    localparam int unsigned RX_ALIGN_MAX_TAPS_DEF = 127;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_NEXT,
        ST_SLIP,
        ST_MOVE,
        ST_DONE,
        ST_FAIL
    } rx_align_state_t;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_PULSE,
        SP_GAP
    } spacer_state_t;

endpackage

// File: rtl/ddr3_lane_rx_align_if.sv
// IOD-facing and sequencer-facing signals of one read-training lane bit.
interface ddr3_lane_rx_align_if;
    import ddr3_phy_pkg::*;

    logic                   START;
    logic [DDR3_LANE_W-1:0] RX_DATA;
    logic                   DELAY_LINE_OUT_OF_RANGE;
    logic                   RX_BIT_SLIP;
    logic                   DELAY_LINE_LOAD;
    logic                   DELAY_LINE_MOVE;
    logic                   DELAY_LINE_DIRECTION;
    logic                   BUSY;
    logic                   DONE;
    logic                   FAIL;
    logic [2:0]             SLIP_COUNT;
    logic [7:0]             TAP_COUNT;
    logic [DDR3_LANE_W-1:0] RX_DATA_OUT;
    logic                   RX_VALID;

    modport master (
        output START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
        input  RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
        input  BUSY, DONE, FAIL, SLIP_COUNT, TAP_COUNT, RX_DATA_OUT, RX_VALID
    );

    modport slave (
        input  START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
        output RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
        output BUSY, DONE, FAIL, SLIP_COUNT, TAP_COUNT, RX_DATA_OUT, RX_VALID
    );

endinterface

// File: rtl/ddr3_lane_rx_align_pulse_spacer.sv
// Issues N one-cycle pulses separated by one idle cycle; done_c flags the final gap cycle.
module ddr3_pulse_spacer
    import ddr3_phy_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic pulse,
    output logic done_c
);

    localparam int unsigned CW = $clog2(N + 1);

    spacer_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SP_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_c  = 1'b0;
        unique case (state_q)
            SP_IDLE: begin
                if (start) begin
                    state_d = SP_PULSE;
                    cnt_d   = '0;
                end
            end
            SP_PULSE: begin
                state_d = SP_GAP;
                cnt_d   = cnt_q + CW'(1);
            end
            SP_GAP: begin
                if (cnt_q == CW'(N)) begin
                    state_d = SP_IDLE;
                    done_c  = 1'b1;
                end else begin
                    state_d = SP_PULSE;
                end
            end
            default: state_d = SP_IDLE;
        endcase
        // An abort kills the burst before the next pulse can be registered.
        if (abort) state_d = SP_IDLE;
        pulse_d = (state_d == SP_PULSE);
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/ddr3_lane_rx_align.sv
// Read-path word alignment for one DDR3 DQ bit: bit-slips, then steps the delay line, until the pattern locks.
module ddr3_lane_rx_align
    import ddr3_phy_pkg::*;
#(
    parameter logic [DDR3_LANE_W-1:0] PATTERN       = RX_ALIGN_PATTERN_DEF,
    parameter int unsigned            SETTLE_CYCLES = 4,
    parameter int unsigned            MATCH_CYCLES  = 16,
    parameter int unsigned            TAPS_PER_STEP = 8,
    parameter int unsigned            MAX_TAPS      = RX_ALIGN_MAX_TAPS_DEF
) (
    input  logic                  FAB_CLK,
    input  logic                  ARST_N,
    ddr3_lane_rx_align_if.slave   bus
);

    rx_align_state_t        state_q, state_d;
    logic [7:0]             settle_q, settle_d;
    logic [7:0]             match_q, match_d;
    logic [2:0]             slip_cnt_q, slip_cnt_d;
    logic [7:0]             tap_q, tap_d;
    logic                   slip_q, slip_d;
    logic                   load_q, load_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fail_q, fail_d;
    logic [DDR3_LANE_W-1:0] rx_out_q, rx_out_d;
    logic                   sp_start_c, sp_abort_c, move_pulse, move_done_c;

    ddr3_pulse_spacer #(.N(TAPS_PER_STEP)) u_spacer (
        .clk    (FAB_CLK),
        .rst_n  (ARST_N),
        .start  (sp_start_c),
        .abort  (sp_abort_c),
        .pulse  (move_pulse),
        .done_c (move_done_c)
    );

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            match_q    <= '0;
            slip_cnt_q <= '0;
            tap_q      <= '0;
            slip_q     <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            rx_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            match_q    <= match_d;
            slip_cnt_q <= slip_cnt_d;
            tap_q      <= tap_d;
            slip_q     <= slip_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            rx_out_q   <= rx_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        match_d    = match_q;
        slip_cnt_d = slip_cnt_q;
        tap_d      = tap_q;
        sp_start_c = 1'b0;
        sp_abort_c = 1'b0;
        if (move_pulse) tap_d = tap_q + 8'd1;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.START) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d  = ST_CHECK;
                    settle_d = '0;
                    match_d  = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (bus.RX_DATA == PATTERN) begin
                    match_d = match_q + 8'd1;
                    if (match_q == 8'(MATCH_CYCLES - 1)) state_d = ST_DONE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (slip_cnt_q != 3'd7) begin
                    state_d = ST_SLIP;
                end else if (({1'b0, tap_q} + 9'(TAPS_PER_STEP)) > 9'(MAX_TAPS)) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d    = ST_MOVE;
                    sp_start_c = 1'b1;
                end
            end
            // After a tap step the count is 7, so this 8th slip wraps it back to 0.
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 3'd1;
                state_d    = ST_SETTLE;
            end
            ST_MOVE: begin
                if (bus.DELAY_LINE_OUT_OF_RANGE) begin
                    state_d    = ST_FAIL;
                    sp_abort_c = 1'b1;
                end else if (move_done_c) begin
                    state_d = ST_SLIP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counters clear on entry to LOAD so they read 0 while the load pulse is out.
        if (state_d == ST_LOAD) begin
            settle_d   = '0;
            match_d    = '0;
            slip_cnt_d = '0;
            tap_d      = '0;
        end

        load_d   = (state_d == ST_LOAD);
        slip_d   = (state_d == ST_SLIP);
        busy_d   = !(state_d inside {ST_IDLE, ST_DONE, ST_FAIL});
        done_d   = (state_d == ST_DONE);
        fail_d   = (state_d == ST_FAIL);
        rx_out_d = (state_d == ST_DONE) ? bus.RX_DATA : '0;
    end

    assign bus.RX_BIT_SLIP          = slip_q;
    assign bus.DELAY_LINE_LOAD      = load_q;
    assign bus.DELAY_LINE_MOVE      = move_pulse;
    assign bus.DELAY_LINE_DIRECTION = move_pulse;
    assign bus.BUSY                 = busy_q;
    assign bus.DONE                 = done_q;
    assign bus.FAIL                 = fail_q;
    assign bus.SLIP_COUNT           = slip_cnt_q;
    assign bus.TAP_COUNT            = tap_q;
    assign bus.RX_DATA_OUT          = rx_out_q;
    assign bus.RX_VALID             = done_q;

endmodule

// File: doc/ddr3_lane_rx_align.md
Name: ddr3_lane_rx_align

Overview:
- Fabric-side read-path training for one DDR3 DQ lane bit, running on the same FAB_CLK as the lane's IOD.
- Consumes the 8-bit deserialized RX_DATA from the IOD and drives RX_BIT_SLIP plus the delay-line controls (LOAD/MOVE/DIRECTION) until a known training pattern is word-aligned and stable.
- Reports DONE/FAIL to the PHY training sequencer and, once aligned, passes the captured read data through with a valid flag.

Parameters:
PATTERN, 8'h0F, training word; all 8 rotations are distinct.
SETTLE_CYCLES, 4, wait after any LOAD/SLIP/MOVE before comparing (1..255).
MATCH_CYCLES, 16, consecutive matching words required to declare lock (1..255).
TAPS_PER_STEP, 8, delay taps advanced when all 8 slips fail (1..255).
MAX_TAPS, 127, tap ceiling; exceeding it means FAIL (width 8).

Ports:
FAB_CLK  in  1  fabric clock, same domain as IOD RX_DATA
ARST_N  in  1  asynchronous active-low reset
START  in  1  1-cycle pulse to begin or restart training
RX_DATA  in  8  deserialized word from IOD
DELAY_LINE_OUT_OF_RANGE  in  1  from IOD; level, sampled in MOVE
RX_BIT_SLIP  out  1  1-cycle pulse to IOD
DELAY_LINE_LOAD  out  1  1-cycle pulse; returns delay to its configured value
DELAY_LINE_MOVE  out  1  1-cycle pulse, one tap per pulse
DELAY_LINE_DIRECTION  out  1  1 = increment; asserted only alongside MOVE
BUSY  out  1  high in any state other than IDLE/DONE/FAIL
DONE  out  1  level, lock achieved
FAIL  out  1  level, training exhausted
SLIP_COUNT  out  3  slips applied since the last tap step
TAP_COUNT  out  8  taps moved since LOAD
RX_DATA_OUT  out  8  registered RX_DATA
RX_VALID  out  1  high while DONE

Behaviour:
- Reset (ARST_N low, asynchronous):
  - State goes to IDLE.
  - All outputs and counters are 0.
  - Deassertion is used as-is; the integrator supplies a synchronized deassert.
- IDLE: START -> LOAD.
- LOAD:
  - Pulse DELAY_LINE_LOAD for 1 cycle.
  - Clear SLIP_COUNT, TAP_COUNT, match counter and settle counter.
  - Next state: SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then go to CHECK with the match counter at 0.
- CHECK:
  - Each cycle: if RX_DATA==PATTERN, increment the match counter; otherwise go to NEXT.
  - When the match counter reaches MATCH_CYCLES -> DONE.
  - Lock decision latency: the cycle that samples the MATCH_CYCLES-th matching word registers DONE=1, visible the following cycle.
- NEXT:
  - If SLIP_COUNT<7: go to SLIP.
  - Otherwise, if TAP_COUNT+TAPS_PER_STEP>MAX_TAPS: go to FAIL (use 9-bit compare, no wrap).
  - Otherwise: go to MOVE.
- SLIP:
  - Pulse RX_BIT_SLIP for 1 cycle.
  - Increment SLIP_COUNT, then go to SETTLE.
- MOVE:
  - Issue TAPS_PER_STEP MOVE pulses with DIRECTION=1, one pulse every 2 cycles (pulse, gap).
  - Increment TAP_COUNT per pulse.
  - If DELAY_LINE_OUT_OF_RANGE is seen high in any cycle of MOVE -> FAIL immediately; no further pulses.
  - After the last pulse, apply one RX_BIT_SLIP (the 8th slip restores the original word boundary), clear SLIP_COUNT, then go to SETTLE.
- DONE:
  - DONE=1, RX_VALID=1, RX_DATA_OUT follows RX_DATA with 1-cycle latency.
  - Outside DONE, RX_DATA_OUT holds 0.
- FAIL: FAIL=1, RX_VALID=0.
- START handling:
  - START while BUSY is ignored.
  - START in DONE or FAIL clears DONE/FAIL the same edge and enters LOAD.
- Mutual exclusion: RX_BIT_SLIP, DELAY_LINE_MOVE and DELAY_LINE_LOAD are never high in the same cycle.
- Pulse spacing: at least SETTLE_CYCLES between any pulse and the next compare.
- Counters hold their values in DONE/FAIL for debug readout.

Decomposition:
- Shared package ddr3_phy_pkg:
  - State enum rx_align_state_t.
  - Defaults for PATTERN and MAX_TAPS.
  - DDR3 lane width constant (8).
- One sub-module, ddr3_pulse_spacer: issues N one-cycle pulses with a 1-cycle gap and reports done, used by MOVE.
- Compare, counters and FSM stay in the top module.

Test Plan:
- IOD model already aligned and clean: START -> no SLIP/MOVE pulses. DONE rises 1+1+4+16+1 cycles after START. TAP_COUNT=0, SLIP_COUNT=0.
- Model word rotated by 5: START -> exactly 3 RX_BIT_SLIP pulses, then DONE. SLIP_COUNT=3, RX_DATA_OUT==8'h0F with RX_VALID=1.
- Data corrupted for taps<16, aligned otherwise: START -> two MOVE bursts of 8 pulses with DIRECTION=1, each followed by one slip. DONE with TAP_COUNT=16.
- Model never matches, MAX_TAPS=20: START -> MOVE bursts at taps 8 and 16, then FAIL. TAP_COUNT=16, no MOVE issued beyond 16.
- DELAY_LINE_OUT_OF_RANGE forced high during the 3rd pulse of the first burst -> FAIL the next cycle, TAP_COUNT=3. A later START re-enters LOAD and clears FAIL.
- ARST_N low mid-CHECK, plus START during SETTLE:
  - Reset forces all outputs to 0 asynchronously.
  - START during SETTLE has no effect on the state sequence.
